// File: rtl/addr_sweep_counter.sv
// Address sweep generator: counts 0..limit (or limit..0) in STEP increments,
// one beat per valid/ready handshake, with optional continuous looping.
module addr_sweep_counter #(
   parameter int WORD_SIZE = 16,
   parameter int STEP      = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [WORD_SIZE-1:0] limit_i,
   input  logic                 down_i,
   input  logic                 loop_i,
   input  logic                 abort_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [WORD_SIZE-1:0] data_o,
   output logic                 last_o,
   output logic                 done_o,
   output logic                 busy_o
);

   localparam logic [WORD_SIZE-1:0] STEP_W = WORD_SIZE'(STEP);
   localparam logic [WORD_SIZE:0]   STEP_X = (WORD_SIZE+1)'(STEP);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [WORD_SIZE-1:0] data;
   logic [WORD_SIZE-1:0] lim;
   logic                 dn;
   logic                 lp;
   logic                 done;
   logic                 last;
   logic                 run;

   assign run = (state == RUN);

   // Up-mode bound check is one bit wider so data + STEP never wraps.
   always_comb begin
      last = 1'b0;
      if (run) begin
         if (dn) last = (data < STEP_W);
         else    last = (({1'b0, data} + STEP_X) > {1'b0, lim});
      end
   end

   always_ff @(posedge clk_i) begin
      done <= 1'b0;
      if (reset_i) begin
         state <= IDLE;
         data  <= '0;
         lim   <= '0;
         dn    <= 1'b0;
         lp    <= 1'b0;
      end else if (state == IDLE) begin
         if (start_i) begin
            state <= RUN;
            lim   <= limit_i;
            dn    <= down_i;
            lp    <= loop_i;
            data  <= down_i ? limit_i : '0;
         end
      end else if (abort_i) begin
         state <= IDLE;
         data  <= '0;
      end else if (ready_i) begin
         if (!last)
            data <= dn ? data - STEP_W : data + STEP_W;
         else if (lp)
            data <= dn ? lim : '0;
         else begin
            state <= IDLE;
            data  <= '0;
            done  <= 1'b1;
         end
      end
   end

   assign valid_o = run;
   assign busy_o  = run;
   assign data_o  = data;
   assign last_o  = last;
   assign done_o  = done;

endmodule

// File: tb/tb_addr_sweep_counter.sv
// Directed bench for addr_sweep_counter: three instances (16b/step1, 16b/step4,
// 4b/step1) share stimulus and are checked every cycle against a beat-index model.
module tb_addr_sweep_counter;

   logic        clk = 1'b0;
   logic        rst, start, down, loop, abort, ready;
   logic [15:0] limit16;
   logic [3:0]  lim4;

   logic [2:0]  v, bz, ls, dnp;
   logic [15:0] dat0, dat1;
   logic [3:0]  dat2;

   always #5 clk = ~clk;

   addr_sweep_counter #(.WORD_SIZE(16), .STEP(1)) u0 (
      .clk_i(clk), .reset_i(rst), .start_i(start), .limit_i(limit16), .down_i(down),
      .loop_i(loop), .abort_i(abort), .ready_i(ready), .valid_o(v[0]), .data_o(dat0),
      .last_o(ls[0]), .done_o(dnp[0]), .busy_o(bz[0]));
   addr_sweep_counter #(.WORD_SIZE(16), .STEP(4)) u1 (
      .clk_i(clk), .reset_i(rst), .start_i(start), .limit_i(limit16), .down_i(down),
      .loop_i(loop), .abort_i(abort), .ready_i(ready), .valid_o(v[1]), .data_o(dat1),
      .last_o(ls[1]), .done_o(dnp[1]), .busy_o(bz[1]));
   addr_sweep_counter #(.WORD_SIZE(4), .STEP(1)) u2 (
      .clk_i(clk), .reset_i(rst), .start_i(start), .limit_i(lim4), .down_i(down),
      .loop_i(loop), .abort_i(abort), .ready_i(ready), .valid_o(v[2]), .data_o(dat2),
      .last_o(ls[2]), .done_o(dnp[2]), .busy_o(bz[2]));

   int n_cmp = 0;
   int n_bad = 0;
   bit en = 0;

   // Model: a sweep is a pass of (lim/S + 1) beats; beat k has value k*S (up)
   // or lim - k*S (down).
   int S[3] = '{1, 4, 1};
   int act[3], k[3], mlim[3], mdn[3], mlp[3], mdone[3];
   int pv[3], pd[3];
   int q0[$], q1[$], q2[$];
   int done_seen;

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_step(input int i, input int lin);
      mdone[i] = 0;
      if (rst) act[i] = 0;
      else if (act[i] == 0) begin
         if (start) begin
            act[i] = 1; k[i] = 0; mlim[i] = lin; mdn[i] = down; mlp[i] = loop;
         end
      end else if (abort) act[i] = 0;
      else if (ready) begin
         if (k[i] == mlim[i] / S[i]) begin
            if (mlp[i] != 0) k[i] = 0;
            else begin act[i] = 0; mdone[i] = 1; end
         end else k[i]++;
      end
   endtask

   function automatic int exp_data(input int i);
      if (act[i] == 0) return 0;
      return (mdn[i] != 0) ? mlim[i] - k[i] * S[i] : k[i] * S[i];
   endfunction

   always @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 3; i++)
            if (pv[i] != 0 && ready && !abort && !rst) begin
               if (i == 0) q0.push_back(pd[i]);
               else if (i == 1) q1.push_back(pd[i]);
               else q2.push_back(pd[i]);
            end
         model_step(0, int'(limit16));
         model_step(1, int'(limit16));
         model_step(2, int'(lim4));
         #1;
         for (int i = 0; i < 3; i++) begin
            int d;
            d = (i == 0) ? int'(dat0) : (i == 1) ? int'(dat1) : int'(dat2);
            chk($sformatf("valid%0d", i), int'(v[i]), act[i]);
            chk($sformatf("busy%0d", i), int'(bz[i]), act[i]);
            chk($sformatf("data%0d", i), d, exp_data(i));
            chk($sformatf("last%0d", i), int'(ls[i]),
                (act[i] != 0 && k[i] == mlim[i] / S[i]) ? 1 : 0);
            chk($sformatf("done%0d", i), int'(dnp[i]), mdone[i]);
            pv[i] = int'(v[i]);
            pd[i] = d;
         end
         if (dnp[0]) done_seen++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(input int l, input int l4, input bit d, input bit lp);
      @(negedge clk);
      limit16 = 16'(l); lim4 = 4'(l4); down = d; loop = lp; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clr();
      q0.delete(); q1.delete(); q2.delete(); done_seen = 0;
   endtask

   initial begin
      int e032[4] = '{0, 1, 2, 3};
      int e033[3] = '{0, 4, 8};
      int e035[3] = '{0, 1, 2};
      int e034[6] = '{2, 1, 0, 2, 1, 0};
      int e037[3] = '{0, 0, 1};

      for (int i = 0; i < 3; i++) begin act[i] = 0; k[i] = 0; mdone[i] = 0; pv[i] = 0; pd[i] = 0; end
      rst = 1; start = 0; down = 0; loop = 0; abort = 0; ready = 1; limit16 = 0; lim4 = 0;
      cyc(2);
      en = 1;
      cyc(1);
      rst = 0;
      chk("rst_valid", int'(v), 0);
      chk("rst_data0", int'(dat0), 0);

      // up sweep 0..3
      clr(); go(3, 3, 0, 0); cyc(6);
      chk("up3_len", q0.size(), 4);
      foreach (e032[i]) chk($sformatf("up3_b%0d", i), q0[i], e032[i]);
      chk("up3_done", done_seen, 1);
      chk("up3_step4_len", q1.size(), 1);

      // stepped sweep, step 4 to limit 10
      clr(); go(10, 10, 0, 0); cyc(13);
      chk("s4_len", q1.size(), 3);
      foreach (e033[i]) chk($sformatf("s4_b%0d", i), q1[i], e033[i]);

      // full range of the 4-bit instance
      clr(); go(15, 15, 0, 0); cyc(18);
      chk("w4_len", q2.size(), 16);
      chk("w4_final", q2[15], 15);

      // limit 0: a single beat
      clr(); go(0, 0, 0, 0); cyc(3);
      chk("l0_len", q0.size(), 1);
      chk("l0_b0", q0[0], 0);
      chk("l0_done", done_seen, 1);

      // backpressure
      clr(); go(2, 2, 0, 0);
      ready = 1; cyc(1); ready = 0; cyc(1); ready = 0; cyc(1);
      ready = 1; cyc(1); ready = 1; cyc(4);
      chk("bp_len", q0.size(), 3);
      foreach (e035[i]) chk($sformatf("bp_b%0d", i), q0[i], e035[i]);

      // down loop, then abort
      clr(); go(2, 2, 1, 1); cyc(7);
      abort = 1; cyc(1); abort = 0; cyc(3);
      foreach (e034[i]) chk($sformatf("dl_b%0d", i), q0[i], e034[i]);
      chk("dl_done", done_seen, 0);
      chk("dl_idle", int'(v[0]), 0);

      // start ignored in RUN, reset mid-sweep, start+abort in IDLE
      clr(); go(5, 5, 0, 0);
      limit16 = 9; start = 1; cyc(1);
      start = 0; rst = 1; cyc(1);
      chk("rs_data0", int'(dat0), 0);
      rst = 0; limit16 = 1; lim4 = 1; start = 1; abort = 1; cyc(1);
      start = 0; abort = 0; cyc(4);
      chk("rs_len", q0.size(), 3);
      foreach (e037[i]) chk($sformatf("rs_b%0d", i), q0[i], e037[i]);
      chk("rs_done", done_seen, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/addr_sweep_counter.md
ADDR_SWEEP_COUNTER -- requirements
Module: addr_sweep_counter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, width of limit_i and data_o.
REQ-002 SHALL have parameter STEP, default 1, increment/decrement per accepted beat; legal range 1..2**WORD_SIZE-1.
REQ-003 SHALL have port clk_i, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit, reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit, launches a sweep when the block is idle.
REQ-006 SHALL have port limit_i, input, WORD_SIZE bits, inclusive sweep bound; sampled only on an accepted start.
REQ-007 SHALL have port down_i, input, 1 bit, direction (0 = up from 0, 1 = down from limit); sampled only on an accepted start.
REQ-008 SHALL have port loop_i, input, 1 bit, continuous-repeat mode; sampled only on an accepted start.
REQ-009 SHALL have port abort_i, input, 1 bit, terminates a sweep.
REQ-010 SHALL have port ready_i, input, 1 bit, downstream accepts the current beat.
REQ-011 SHALL have port valid_o, output, 1 bit, data_o holds a valid beat.
REQ-012 SHALL have port data_o, output, WORD_SIZE bits, current count value.
REQ-013 SHALL have port last_o, output, 1 bit, current beat is the final beat of a pass.
REQ-014 SHALL have port done_o, output, 1 bit, one-cycle pulse on completion of a non-looping sweep.
REQ-015 SHALL have port busy_o, output, 1 bit, high while in RUN.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and RUN; beat accepted = valid_o && ready_i.
REQ-017 In IDLE, start_i=1 SHALL latch limit_i/down_i/loop_i, load data_o with 0 (up) or limit_i (down), and enter RUN next cycle, so valid_o is high 1 cycle after start_i.
REQ-018 start_i SHALL be ignored while in RUN.
REQ-019 In RUN, valid_o SHALL be 1 and busy_o 1; in IDLE both SHALL be 0 and data_o SHALL be 0.
REQ-020 Without an accepted beat, data_o and last_o SHALL hold (stall).
REQ-021 Up mode: last_o SHALL be 1 iff data_o + STEP > latched limit, computed in WORD_SIZE+1 bits so no wrap-around occurs.
REQ-022 Down mode: last_o SHALL be 1 iff data_o < STEP.
REQ-023 On an accepted beat with last_o=0, data_o SHALL advance by +STEP (up) or -STEP (down) next cycle.
REQ-024 On an accepted beat with last_o=1 and latched loop=1, data_o SHALL reload the start value and stay in RUN with no bubble.
REQ-025 On an accepted beat with last_o=1 and latched loop=0, the FSM SHALL enter IDLE, and done_o SHALL be 1 for exactly the following cycle.
REQ-026 limit=0 SHALL produce a single beat of value 0 with last_o=1.
REQ-027 abort_i in RUN SHALL force IDLE next cycle regardless of ready_i, with no done_o pulse; abort takes priority over a simultaneous handshake.
REQ-028 abort_i in IDLE SHALL have no effect; if start_i and abort_i are both high in IDLE, start SHALL win.
REQ-029 Changes on limit_i/down_i/loop_i during RUN SHALL NOT affect the sweep in progress.

Reset
REQ-030 reset_i=1 at a clock edge SHALL force IDLE with valid_o=0, data_o=0, last_o=0, done_o=0, busy_o=0, overriding start_i and abort_i.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep; no done_o pulse SHALL follow.

Verification
REQ-032 Up sweep: STEP=1, limit=3, down=0, loop=0, ready_i=1 -> data 0,1,2,3 on consecutive cycles starting 1 cycle after start; last_o on 3; done_o the cycle after; valid_o then 0.
REQ-033 Stepped up sweep: STEP=4, limit=10 -> beats 0,4,8 with last_o on 8; no value above 10 is emitted.
REQ-034 Down loop: STEP=1, limit=2, down=1, loop=1 -> 2,1,0,2,1,0,... with no bubbles and no done_o; abort_i -> valid_o=0 next cycle, done_o stays 0.
REQ-035 Backpressure: limit=2, ready_i toggled 1,0,0,1,1 -> data_o holds during ready_i=0; exactly 3 beats are accepted, values 0,1,2.
REQ-036 Edge cases: limit=0 -> one beat 0 with last_o=1 then done_o; WORD_SIZE=4, STEP=1, limit=15 -> final beat 15 with last_o=1, no wrap to 0.
REQ-037 Reset mid-sweep at data_o=1 -> next cycle all outputs 0; a start_i during RUN is ignored and a start_i after reset launches a new sweep.
